// File: rtl/prefix_adder8_pkg.sv
// Shared constants for the Sklansky parallel-prefix adder.
package prefix_adder8_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int LEVELS        = $clog2(WIDTH_DEFAULT);

endpackage : prefix_adder8_pkg

// File: rtl/prefix_gp_cell.sv
// Black cell: merges a high group (Gh, Ph) with the adjacent lower group (Gl, Pl).
module prefix_gp_cell (
    input  logic Gh,
    input  logic Ph,
    input  logic Gl,
    input  logic Pl,
    output logic G,
    output logic P
);

    assign G = Gh | (Ph & Gl);
    assign P = Ph & Pl;

endmodule : prefix_gp_cell

// File: rtl/prefix_adder8.sv
// Sklansky parallel-prefix adder with cin folded in as prefix column -1,
// followed by a single output register stage (1-cycle latency).
module prefix_adder8
    import prefix_adder8_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    // One tree level per bit of a column index; cin occupies column 0, so the
    // WIDTH+1 columns need $clog2(WIDTH)+1 levels.
    localparam int TREE_LEVELS = $clog2(WIDTH) + 1;

    // Column 0 holds cin (G=cin, P=0); column i+1 holds bit i of the operands.
    logic [WIDTH:0] g_init;
    logic [WIDTH:0] p_init;

    assign g_init = {a & b, cin};
    assign p_init = {a ^ b, 1'b0};

    for (genvar l = 0; l < TREE_LEVELS; l++) begin : lvl
        logic [WIDTH:0] g_in;
        logic [WIDTH:0] p_in;
        logic [WIDTH:0] g_out;
        logic [WIDTH:0] p_out;

        if (l == 0) begin : g_first
            assign g_in = g_init;
            assign p_in = p_init;
        end else begin : g_next
            assign g_in = lvl[l-1].g_out;
            assign p_in = lvl[l-1].p_out;
        end

        for (genvar j = 0; j <= WIDTH; j++) begin : col
            // Sklansky: a column whose index has bit l set merges with the
            // top column of the lower half of its 2^(l+1)-wide block.
            if (((j >> l) % 2) == 1) begin : g_black
                localparam int LO = ((j >> l) << l) - 1;

                prefix_gp_cell u_cell (
                    .Gh (g_in[j]),
                    .Ph (p_in[j]),
                    .Gl (g_in[LO]),
                    .Pl (p_in[LO]),
                    .G  (g_out[j]),
                    .P  (p_out[j])
                );
            end else begin : g_pass
                assign g_out[j] = g_in[j];
                assign p_out[j] = p_in[j];
            end
        end
    end

    // g_fin[i] is the group generate over columns i..0, i.e. the carry into bit i.
    logic [WIDTH:0]   g_fin;
    logic [WIDTH-1:0] sum_next;
    logic             unused_p_fin;

    assign g_fin        = lvl[TREE_LEVELS-1].g_out;
    assign sum_next     = p_init[WIDTH:1] ^ g_fin[WIDTH-1:0];
    assign unused_p_fin = ^lvl[TREE_LEVELS-1].p_out;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s    <= '0;
            cout <= 1'b0;
        end else begin
            s    <= sum_next;
            cout <= g_fin[WIDTH];
        end
    end

endmodule : prefix_adder8

// File: tb/tb_prefix_adder8.sv
// Self-checking bench for prefix_adder8: directed table, reset sequence,
// structured sweeps and random vectors against an arithmetic reference.
module tb_prefix_adder8;

    logic       clk;
    logic       reset_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       cout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_s;
        logic       exp_cout;
    } vec_t;

    prefix_adder8 #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .s       (s),
        .cout    (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 9-bit integer addition.
    function automatic logic [8:0] ref_sum(input logic [7:0] x, input logic [7:0] y,
                                           input logic c);
        int unsigned total;
        total = 32'(x) + 32'(y) + 32'(c);
        return total[8:0];
    endfunction

    task automatic check(input string name, input logic [8:0] actual,
                         input logic [8:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got cout=%b s=%h, expected cout=%b s=%h",
                     name, actual[8], actual[7:0], expected[8], expected[7:0]);
        end
    endtask

    // Drive one vector away from the edge, then sample just after the capturing edge.
    task automatic apply(input logic [7:0] ta, input logic [7:0] tb_val, input logic tc);
        @(negedge clk);
        a   = ta;
        b   = tb_val;
        cin = tc;
        @(posedge clk);
        #1;
    endtask

    vec_t table_v[$];

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [7:0] pat[6];

        table_v.push_back('{8'h17, 8'h13, 1'b0, 8'h2A, 1'b0});
        table_v.push_back('{8'h07, 8'h4C, 1'b0, 8'h53, 1'b0});
        table_v.push_back('{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1});
        table_v.push_back('{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1});
        table_v.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
        table_v.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
        table_v.push_back('{8'h00, 8'h00, 1'b1, 8'h01, 1'b0});
        table_v.push_back('{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0});
        table_v.push_back('{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1});
        table_v.push_back('{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0});
        table_v.push_back('{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0});
        table_v.push_back('{8'hFE, 8'h01, 1'b1, 8'h00, 1'b1});

        reset_n = 1'b0;
        a       = 8'hA5;
        b       = 8'h5A;
        cin     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {cout, s}, 9'h000);

        @(negedge clk);
        reset_n = 1'b1;

        foreach (table_v[i]) begin
            apply(table_v[i].a, table_v[i].b, table_v[i].cin);
            check($sformatf("table[%0d]", i), {cout, s},
                  {table_v[i].exp_cout, table_v[i].exp_s});
        end

        // Asynchronous reset between edges while s=0x53.
        apply(8'h07, 8'h4C, 1'b0);
        check("pre_reset", {cout, s}, 9'h053);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_reset_clear", {cout, s}, 9'h000);
        a   = 8'hF0;
        b   = 8'h33;
        cin = 1'b1;
        @(posedge clk);
        #1;
        check("reset_holds_over_edge", {cout, s}, 9'h000);
        @(negedge clk);
        reset_n = 1'b1;
        a       = 8'h01;
        b       = 8'h01;
        cin     = 1'b1;
        #1;
        check("released_before_edge", {cout, s}, 9'h000);
        @(posedge clk);
        #1;
        check("first_after_release", {cout, s}, 9'h003);

        // Structured sweep: every (a, cin) against boundary partners of b.
        for (int x = 0; x < 256; x++) begin
            ra     = 8'(x);
            pat[0] = 8'h00;
            pat[1] = 8'hFF;
            pat[2] = ~ra;
            pat[3] = ra;
            pat[4] = 8'h01;
            pat[5] = 8'h80;
            for (int k = 0; k < 6; k++) begin
                for (int c = 0; c < 2; c++) begin
                    apply(ra, pat[k], 1'(c));
                    check($sformatf("sweep a=%h b=%h cin=%0d", ra, pat[k], c),
                          {cout, s}, ref_sum(ra, pat[k], 1'(c)));
                end
            end
        end

        // Random vectors, one per cycle.
        for (int n = 0; n < 30000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            apply(ra, rb, rc);
            check($sformatf("random a=%h b=%h cin=%b", ra, rb, rc),
                  {cout, s}, ref_sum(ra, rb, rc));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_prefix_adder8

// File: doc/prefix_adder8.md
PREFIX_ADDER8 -- requirements
Module: prefix_adder8

Interface
REQ-001 Parameter WIDTH, default 8, operand/sum width; SHALL be a power of two >= 2; all requirements below use WIDTH=8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 a  input  WIDTH  addend A, unsigned.
REQ-005 b  input  WIDTH  addend B, unsigned.
REQ-006 cin  input  1  carry-in.
REQ-007 s  output  WIDTH  registered sum (a + b + cin) mod 2^WIDTH.
REQ-008 cout  output  1  registered carry-out, bit WIDTH of a + b + cin.

Function
REQ-009 Bitwise generate/propagate SHALL be formed as g[i] = a[i]&b[i] and p[i] = a[i]^b[i].
REQ-010 cin SHALL enter as prefix column -1 with G[-1] = cin and P[-1] = 0.
REQ-011 Group G/P SHALL be computed by a Sklansky parallel-prefix tree of log2(WIDTH)+1 levels (4 for WIDTH=8), no ripple chains.
REQ-012 Each black cell SHALL compute G = Gh | (Ph & Gl) and P = Ph & Pl.
REQ-013 Carry into bit i SHALL be G[i-1:-1]; s[i] = p[i] ^ G[i-1:-1]; cout = G[WIDTH-1:-1].
REQ-014 Adder core SHALL be purely combinational; its result SHALL be captured into s/cout on each rising clk edge.
REQ-015 Latency SHALL be exactly 1 cycle: inputs stable before edge N appear on s/cout after edge N; new result every cycle, no handshake.
REQ-016 Overflow SHALL wrap modulo 2^WIDTH with the overflow bit reported only on cout.
REQ-017 X/Z-free inputs SHALL always yield X-free outputs; no internal state besides the output registers.

Reset
REQ-018 While reset_n = 0, s SHALL be 0 and cout SHALL be 0, asserted asynchronously without waiting for clk.
REQ-019 Reset asserted mid-operation SHALL discard the pending result; the first valid result SHALL appear on the first rising edge after reset_n deasserts.
REQ-020 Deassertion SHALL be sampled synchronously to clk.

Structure
REQ-021 A shared package SHALL hold WIDTH default and derived constant LEVELS = $clog2(WIDTH).
REQ-022 Black cell SHALL be one sub-module, prefix_gp_cell (inputs Gh, Ph, Gl, Pl; outputs G, P), instantiated by generate loops.
REQ-023 The output register SHALL reside in prefix_adder8 itself, not in the sub-module.

Verification
REQ-024 a=0x17, b=0x13, cin=0, one clock -> s=0x2A, cout=0.
REQ-025 a=0x07, b=0x4C, cin=0, one clock -> s=0x53, cout=0.
REQ-026 a=0xFF, b=0x00, cin=1 -> s=0x00, cout=1, carry through full prefix span.
REQ-027 a=0xFF, b=0xFF, cin=1 -> s=0xFF, cout=1; a=0x80, b=0x80, cin=0 -> s=0x00, cout=1.
REQ-028 reset_n pulsed low between edges while s=0x53 -> s=0x00 and cout=0 immediately; after release, next edge with a=0x01, b=0x01, cin=1 -> s=0x03.
REQ-029 Exhaustive sweep of all 2^17 (a, b, cin) combinations, one per cycle -> each s/cout one cycle later matches the reference sum, zero mismatches.
